// File: rtl/event_capture_fifo.sv
// -----------------------------------------------------------------------------
// event_capture_fifo
//
// Input stage for the 2D convolution's event port. Spike events arrive over a
// valid/ready interface, events that cannot be processed (empty spike vector or
// coordinates off the image) are discarded and counted, and the remaining
// events are buffered in a small circular FIFO. One event at a time is moved
// into an output register and held until the convolution acknowledges it. A
// one-cycle valid-low gap follows each acknowledge so a consumer still
// sampling after its ack cannot capture the same event twice.
//
// Optional build feature (macro EVENT_COALESCE_EN):
//   When defined, an accepted event whose (x,y) matches the newest entry still
//   held in the FIFO has its spikes ORed into that entry instead of taking a
//   new slot. When undefined, every accepted event takes its own entry.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   in_valid/ready   upstream handshake (ready = not full and not in reset)
//   in_x/in_y        event coordinates
//   in_spikes        per-channel spike bits
//   event_x/y/spikes presented event (stable while event_valid is high)
//   event_valid      presented event valid
//   event_ack        consumer captured the presented event
//   fifo_count       FIFO occupancy, not counting the output register
//   drop_count       saturating count of discarded events
// -----------------------------------------------------------------------------
module event_capture_fifo #(
  parameter int COORD_BITS  = 8,
  parameter int IN_CHANNELS = 4,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COORD_BITS-1:0]         in_x,
  input  logic [COORD_BITS-1:0]         in_y,
  input  logic [IN_CHANNELS-1:0]        in_spikes,
  output logic [COORD_BITS-1:0]         event_x,
  output logic [COORD_BITS-1:0]         event_y,
  output logic [IN_CHANNELS-1:0]        event_spikes,
  output logic                          event_valid,
  input  logic                          event_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [COORD_BITS-1:0]  x;
    logic [COORD_BITS-1:0]  y;
    logic [IN_CHANNELS-1:0] spikes;
  } event_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  // Storage and state
  event_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [15:0]     drop_q,   drop_d;
  event_t          out_q,    out_d;
  state_t          state_q,  state_d;

  // Handshake and filter
  logic full;
  logic xfer;
  logic in_ok;
  logic accept;
  logic drop;
  logic push;
  logic pop;
  logic merge;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign in_ready = !full && !rst;
  assign xfer     = in_valid && in_ready;

  assign in_ok  = (|in_spikes) &&
                  (int'(in_x) < IMG_WIDTH) &&
                  (int'(in_y) < IMG_HEIGHT);
  assign accept = xfer && in_ok;
  assign drop   = xfer && !in_ok;

`ifdef EVENT_COALESCE_EN
  // The newest entry sits just behind the write pointer. It is only a merge
  // target while it stays in the FIFO through this edge: if it is the single
  // entry and is being popped now, the merged spikes would be lost.
  logic [PW-1:0] last_idx;
  event_t        last_ev;

  assign last_idx = wr_ptr_q - PW'(1);
  assign last_ev  = mem_q[last_idx];
  assign merge    = accept && (count_q != '0) &&
                    !(pop && (count_q == CW'(1))) &&
                    (last_ev.x == in_x) && (last_ev.y == in_y);
`else
  assign merge = 1'b0;
`endif

  assign push = accept && !merge;

  // Output FSM: next state and pop decision
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (event_ack) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Pointer, occupancy, drop counter and output register next state
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    out_d    = pop  ? mem_q[rd_ptr_q]   : out_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      out_q    <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      out_q    <= out_d;
      state_q  <= state_d;
    end
  end

  // NOTE: the storage array has no reset; contents are only read after a
  // write, so clearing it would just cost reset routing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= event_t'{x: in_x, y: in_y, spikes: in_spikes};
`ifdef EVENT_COALESCE_EN
    if (merge) mem_q[last_idx].spikes <= last_ev.spikes | in_spikes;
`endif
  end

  assign event_valid  = (state_q == ST_PRESENT);
  assign event_x      = out_q.x;
  assign event_y      = out_q.y;
  assign event_spikes = out_q.spikes;
  assign fifo_count   = count_q;
  assign drop_count   = drop_q;

endmodule
